// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_op_t;

    function automatic int unsigned shift_layers(int unsigned n);
        return unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 multiplexer cell.
module mux2 (
    input  logic sel_i,
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/shift_stage.sv
// One shifter layer (shift by 2^K when shamt[K] is set) followed by an elastic register stage.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned K = 0,
    localparam int unsigned L = shift_layers(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [N-1:0] data_i,
    input  logic [L-1:0] shamt_i,
    input  shift_op_t    op_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] data_o,
    output logic [L-1:0] shamt_o,
    output shift_op_t    op_o
);

    localparam int unsigned D = 1 << K;

    logic [N-1:0] layer;
    logic         valid_q;
    logic [N-1:0] data_q;
    logic [L-1:0] shamt_q;
    shift_op_t    op_q;
    logic         load;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic left_bit;
        logic right_bit;
        logic shifted_bit;

        if (i >= D) begin : g_left
            assign left_bit = data_i[i-D];
        end else begin : g_left_zero
            assign left_bit = 1'b0;
        end

        if (i + D < N) begin : g_right
            assign right_bit = data_i[i+D];
        end else begin : g_right_fill
            // Top bits of a right shift: sign, wrapped bottom bits, or zero.
            always_comb begin
                case (op_i)
                    SHIFT_SRA: right_bit = data_i[N-1];
                    SHIFT_ROR: right_bit = data_i[i+D-N];
                    default:   right_bit = 1'b0;
                endcase
            end
        end

        assign shifted_bit = (op_i == SHIFT_SLL) ? left_bit : right_bit;

        mux2 u_mux (
            .sel_i (shamt_i[K]),
            .a_i   (data_i[i]),
            .b_i   (shifted_bit),
            .y_o   (layer[i])
        );
    end

    assign ready_o = !valid_q || ready_i;
    assign load    = ready_o && valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
        end
    end

    // Payload only moves on a real transfer so a stalled item stays put.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SHIFT_SLL;
        end else if (load) begin
            data_q  <= layer;
            shamt_q <= shamt_i;
            op_q    <= op_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined N-bit barrel shifter: log2(N) shift layers, each registered, with valid/ready flow control.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned N = 32,
    localparam int unsigned L = shift_layers(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] in_shamt,
    input  shift_op_t    in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic [L:0]   valid;
    logic [L:0]   ready;
    logic [N-1:0] data  [L+1];
    logic [L-1:0] shamt [L+1];
    shift_op_t    op    [L+1];
    logic         unused_tail;

    assign valid[0] = in_valid;
    assign data[0]  = in_data;
    assign shamt[0] = in_shamt;
    assign op[0]    = in_op;
    assign ready[L] = out_ready;

    for (genvar k = 0; k < L; k++) begin : g_stage
        shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (valid[k]),
            .ready_o (ready[k]),
            .data_i  (data[k]),
            .shamt_i (shamt[k]),
            .op_i    (op[k]),
            .valid_o (valid[k+1]),
            .ready_i (ready[k+1]),
            .data_o  (data[k+1]),
            .shamt_o (shamt[k+1]),
            .op_o    (op[k+1])
        );
    end

    assign in_ready    = ready[0];
    assign out_valid   = valid[L];
    assign out_data    = data[L];
    assign unused_tail = ^{shamt[L], op[L]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and scoreboard-checked bench for pipelined_shifter at N=8.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    localparam int unsigned N = 8;
    localparam int unsigned L = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic [L-1:0] in_shamt = '0;
    shift_op_t    in_op = SHIFT_SLL;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_shifter #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input shift_op_t op);
        logic [15:0] dd;
        case (op)
            SHIFT_SLL: return d << s;
            SHIFT_SRL: return d >> s;
            SHIFT_SRA: return 8'($signed(d) >>> s);
            default: begin
                dd = {d, d} >> s;
                return dd[7:0];
            end
        endcase
    endfunction

    task automatic drive(input logic [7:0] d, input logic [2:0] s, input shift_op_t op);
        in_data  = d;
        in_shamt = s;
        in_op    = op;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_basic_ops();
        logic [7:0] vd [7] = '{8'h81, 8'h80, 8'h90, 8'h01, 8'hFF, 8'h7F, 8'h81};
        logic [2:0] vs [7] = '{3'd1, 3'd7, 3'd2, 3'd3, 3'd7, 3'd7, 3'd1};
        shift_op_t  vo [7] = '{SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR,
                               SHIFT_SLL, SHIFT_SRA, SHIFT_ROR};
        logic [7:0] ve [7] = '{8'h02, 8'h01, 8'hE4, 8'h20, 8'h80, 8'h00, 8'hC0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_%0d: out_valid %b want 0", i, out_valid); end
            drive(vd[i], vs[i], vo[i]);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency_%0d: got %0d want 3", i, lat); end
            n_cmp++; if (out_data !== ve[i]) begin n_err++; $display("FAIL basic_data_%0d: got %h want %h", i, out_data, ve[i]); end
        end
    endtask

    task automatic test_passthrough();
        shift_op_t ops [4] = '{SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(8'hA5, 3'd0, ops[i]);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_err++; $display("FAIL pass_%0d: valid %b data %h want 1 a5", i, out_valid, out_data); end
        end
    endtask

    task automatic test_streaming();
        logic [7:0] sd [16] = '{8'h01, 8'h01, 8'hF0, 8'hF0, 8'hFF, 8'h80, 8'h40, 8'hC3,
                                8'h12, 8'h80, 8'h0F, 8'h55, 8'hAA, 8'h55, 8'h36, 8'h3C};
        logic [2:0] ss [16] = '{3'd0, 3'd4, 3'd3, 3'd4, 3'd1, 3'd7, 3'd6, 3'd1,
                                3'd4, 3'd7, 3'd2, 3'd1, 3'd5, 3'd2, 3'd5, 3'd2};
        shift_op_t  so [16] = '{SHIFT_SLL, SHIFT_SLL, SHIFT_SLL, SHIFT_SRL, SHIFT_SRL, SHIFT_SRA,
                                SHIFT_SRA, SHIFT_SRA, SHIFT_ROR, SHIFT_ROR, SHIFT_ROR, SHIFT_SLL,
                                SHIFT_SRL, SHIFT_SRA, SHIFT_ROR, SHIFT_SLL};
        logic [7:0] se [16] = '{8'h01, 8'h10, 8'h80, 8'h0F, 8'h7F, 8'hFF, 8'h01, 8'hE1,
                                8'h21, 8'h01, 8'hC3, 8'hAA, 8'h05, 8'h15, 8'hB1, 8'hF0};
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    drive(sd[i], ss[i], so[i]);
                    in_valid = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int w = 0;
                @(negedge clk);
                while (out_valid !== 1'b1 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 16; i++) begin
                    n_cmp++; if (out_valid !== 1'b1 || out_data !== se[i]) begin n_err++; $display("FAIL stream_%0d: valid %b data %h want 1 %h", i, out_valid, out_data, se[i]); end
                    @(negedge clk);
                end
            end
        join
    endtask

    task automatic test_backpressure();
        logic [7:0] bd [4] = '{8'h11, 8'h88, 8'h03, 8'hFF};
        logic [2:0] bs [4] = '{3'd1, 3'd3, 3'd1, 3'd2};
        shift_op_t  bo [4] = '{SHIFT_SLL, SHIFT_SRA, SHIFT_ROR, SHIFT_SRL};
        logic [7:0] be [3] = '{8'h22, 8'hF1, 8'h81};
        int acc = 0;
        int idx = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            drive(bd[idx], bs[idx], bo[idx]);
            in_valid = 1'b1;
            if (c >= 3) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin n_err++; $display("FAIL bp_hold_%0d: valid %b data %h want 1 22", c, out_valid, out_data); end
            end
            if (in_ready === 1'b1) begin
                acc++;
                idx++;
            end
        end
        n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL bp_accepted: got %0d want 3", acc); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== be[j]) begin n_err++; $display("FAIL bp_drain_%0d: valid %b data %h want 1 %h", j, out_valid, out_data, be[j]); end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_random_stall();
        logic [7:0] q [$];
        int sent = 0;
        int cyc = 0;
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                drive(8'($urandom), 3'($urandom), shift_op_t'(2'($urandom_range(0, 3))));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_unexpected: data %h with empty scoreboard", out_data);
                end else begin
                    if (out_data !== q[0]) begin n_err++; $display("FAIL rand_data: got %h want %h", out_data, q[0]); end
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(ref_shift(in_data, in_shamt, in_op));
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (cyc >= 20000) begin n_err++; $display("FAIL rand_timeout: sent %0d pending %0d", sent, q.size()); end
    endtask

    task automatic test_reset_midstream();
        int w = 0;
        int stale = 0;
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        drive(8'h0F, 3'd1, SHIFT_SLL);
        in_valid = 1'b1;
        @(negedge clk);
        drive(8'hF0, 3'd4, SHIFT_SRL);
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h1E) begin n_err++; $display("FAIL rst_pre: valid %b data %h want 1 1e", out_valid, out_data); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_out_data: got %h want 00", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rst_stale: got %0d stale cycles want 0", stale); end
        drive(8'h01, 3'd1, SHIFT_ROR);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 3 || out_data !== 8'h80) begin n_err++; $display("FAIL rst_after: latency %0d data %h want 3 80", lat, out_data); end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_passthrough();
        test_streaming();
        test_backpressure();
        test_random_stall();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
